// File: rtl/ser_pkg.sv
// Shared constants, FSM state type and PRBS7 helpers for the word serializer.
// The PRBS helpers are only referenced when SER_PRBS_IDLE_EN is defined.
package ser_pkg;

  localparam int DIN_W_DEF = 32;
  localparam int OUT_W_DEF = 8;
  localparam int CNT_W_DEF = 16;
  localparam logic [7:0] IDLE_PAT_DEF = 8'hBC;
  localparam int RATIO = DIN_W_DEF / OUT_W_DEF;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  // x^7 + x^6 + 1: the new bit is the XOR of the two oldest state bits.
  localparam logic [6:0] PRBS7_SEED  = 7'h7F;
  localparam int         PRBS7_TAP_A = 6;
  localparam int         PRBS7_TAP_B = 5;

  function automatic logic [6:0] prbs7_adv(input logic [6:0] s, input int n);
    logic [6:0] r;
    r = s;
    for (int i = 0; i < n; i++) begin
      r = {r[5:0], r[PRBS7_TAP_A] ^ r[PRBS7_TAP_B]};
    end
    return r;
  endfunction

  function automatic logic [63:0] prbs7_slice(input logic [6:0] s, input int n);
    logic [6:0]  r;
    logic [63:0] o;
    r = s;
    o = '0;
    for (int i = 0; i < n && i < 64; i++) begin
      o[i] = r[PRBS7_TAP_A] ^ r[PRBS7_TAP_B];
      r    = {r[5:0], o[i]};
    end
    return o;
  endfunction

endpackage

// File: rtl/prbs7_gen.sv
// Parallel PRBS7 generator: slice_o is the next OUT_W sequence bits (bit 0 first).
// The state advances by OUT_W steps whenever en_i is high.
module prbs7_gen
  import ser_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [OUT_W-1:0] slice_o
);

  // The slice for the seed itself is shown by the parent while in reset,
  // so the register starts one slice further along.
  localparam logic [6:0] RST_STATE = prbs7_adv(PRBS7_SEED, OUT_W);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_d;

  always_comb begin
    lfsr_d  = lfsr_q;
    slice_o = '0;
    for (int i = 0; i < OUT_W; i++) begin
      slice_o[i] = lfsr_d[PRBS7_TAP_A] ^ lfsr_d[PRBS7_TAP_B];
      lfsr_d     = {lfsr_d[5:0], slice_o[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= RST_STATE;
    end else if (en_i) begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/word_serializer.sv
// Word-to-slice serializer with a one-word holding register and underrun counter.
// Define SER_PRBS_IDLE_EN to fill idle slices with PRBS7 instead of IDLE_PAT.
module word_serializer
  import ser_pkg::*;
#(
  parameter int               DIN_W    = DIN_W_DEF,
  parameter int               OUT_W    = OUT_W_DEF,
  parameter logic [OUT_W-1:0] IDLE_PAT = OUT_W'(IDLE_PAT_DEF),
  parameter int               CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIN_W-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [OUT_W-1:0] dout,
  output logic             sof,
  output logic             idle,
  output logic [CNT_W-1:0] underrun_cnt,
  input  logic             clr_cnt
);

  localparam int            SLICES = DIN_W / OUT_W;
  localparam int            CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CW-1:0] LAST   = CW'(SLICES - 1);

  ser_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [DIN_W-1:0] shreg_q;
  logic [DIN_W-1:0] hold_q;
  logic             hold_v_q;
  logic [OUT_W-1:0] dout_q;
  logic             sof_q;
  logic             idle_q;
  logic [CNT_W-1:0] ucnt_q;

  logic             xfer;
  logic             last_slice;
  logic             underrun;
  logic [OUT_W-1:0] fill;

  assign din_ready  = ~hold_v_q;
  assign xfer       = din_valid & din_ready;
  assign last_slice = (state_q == ST_SHIFT) && (cnt_q == LAST);
  assign underrun   = last_slice && !hold_v_q && !xfer;

`ifdef SER_PRBS_IDLE_EN
  localparam logic [63:0]      RST_FILL_W = prbs7_slice(PRBS7_SEED, OUT_W);
  localparam logic [OUT_W-1:0] RST_FILL   = RST_FILL_W[OUT_W-1:0];

  // Only cycles that will actually show idle fill consume PRBS bits.
  logic fill_adv;
  assign fill_adv = underrun || ((state_q == ST_IDLE) && !xfer);

  prbs7_gen #(
    .OUT_W(OUT_W)
  ) u_prbs (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (fill_adv),
    .slice_o(fill)
  );
`else
  localparam logic [OUT_W-1:0] RST_FILL = IDLE_PAT;
  assign fill = IDLE_PAT;
`endif

  // dout always shows the slice for the current cnt_q; shreg keeps the
  // not-yet-sent slices right-aligned so slice k+1 sits at [2*OUT_W-1:OUT_W].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      dout_q   <= RST_FILL;
      sof_q    <= 1'b0;
      idle_q   <= 1'b1;
      ucnt_q   <= '0;
    end else begin
      sof_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            shreg_q <= din;
            dout_q  <= din[OUT_W-1:0];
            sof_q   <= 1'b1;
            idle_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_SHIFT;
          end else begin
            dout_q <= fill;
            idle_q <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (cnt_q != LAST) begin
            shreg_q <= shreg_q >> OUT_W;
            dout_q  <= shreg_q[2*OUT_W-1:OUT_W];
            cnt_q   <= cnt_q + 1'b1;
            if (xfer) begin
              hold_q   <= din;
              hold_v_q <= 1'b1;
            end
          end else if (hold_v_q) begin
            shreg_q  <= hold_q;
            dout_q   <= hold_q[OUT_W-1:0];
            sof_q    <= 1'b1;
            hold_v_q <= 1'b0;
            cnt_q    <= '0;
          end else if (xfer) begin
            shreg_q <= din;
            dout_q  <= din[OUT_W-1:0];
            sof_q   <= 1'b1;
            cnt_q   <= '0;
          end else begin
            dout_q  <= fill;
            idle_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (clr_cnt) begin
        ucnt_q <= '0;
      end else if (underrun && (ucnt_q != '1)) begin
        ucnt_q <= ucnt_q + 1'b1;
      end
    end
  end

  assign dout         = dout_q;
  assign sof          = sof_q;
  assign idle         = idle_q;
  assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer: a slice-queue model predicts every cycle,
// a separate monitor compares on the falling edge. Honours SER_PRBS_IDLE_EN.
module tb_word_serializer;

  typedef struct {
    logic [7:0] data;
    logic       sof;
  } slice_t;

  typedef struct {
    logic        idle;
    logic        ready;
    logic [15:0] ucnt;
    logic [3:0]  ucnt4;
    logic [7:0]  fill;
  } cyc_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] din;
  logic        din_valid;
  logic        clr_cnt;
  logic        din_ready, sof, idle;
  logic [7:0]  dout;
  logic [15:0] underrun_cnt;
  logic        din_ready4, sof4, idle4;
  logic [7:0]  dout4;
  logic [3:0]  underrun_cnt4;

  int compared   = 0;
  int mismatched = 0;

  slice_t pend[$];
  slice_t dataQ[$];
  cyc_t   cycQ[$];
  bit          prevData;
  bit          mReady;
  bit          lastXfer;
  bit          monOn;
  logic [15:0] mUcnt;
  logic [3:0]  mUcnt4;
  int          prbsIdx;

  word_serializer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .dout        (dout),
    .sof         (sof),
    .idle        (idle),
    .underrun_cnt(underrun_cnt),
    .clr_cnt     (clr_cnt)
  );

  word_serializer #(.CNT_W(4)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready4),
    .dout        (dout4),
    .sof         (sof4),
    .idle        (idle4),
    .underrun_cnt(underrun_cnt4),
    .clr_cnt     (clr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SER_PRBS_IDLE_EN
  // Reference PRBS7 bit stream: seven seed ones followed by b[n] = b[n-7] ^ b[n-6].
  logic prbsBits[$];

  function automatic logic [7:0] fillNow();
    logic [7:0] r;
    if (prbsBits.size() == 0) begin
      for (int i = 0; i < 7; i++) prbsBits.push_back(1'b1);
    end
    while (prbsBits.size() < 7 + 8 * (prbsIdx + 1)) begin
      prbsBits.push_back(prbsBits[prbsBits.size() - 7] ^ prbsBits[prbsBits.size() - 6]);
    end
    for (int i = 0; i < 8; i++) r[i] = prbsBits[7 + 8 * prbsIdx + i];
    return r;
  endfunction
`else
  function automatic logic [7:0] fillNow();
    return 8'hBC;
  endfunction
`endif

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  task automatic resetModel();
    pend.delete();
    dataQ.delete();
    cycQ.delete();
    prevData = 1'b0;
    mReady   = 1'b1;
    mUcnt    = '0;
    mUcnt4   = '0;
    prbsIdx  = 0;
  endtask

  task automatic checkReset();
    checkOutput("rst_dout", 32'(dout), 32'(fillNow()));
    checkOutput("rst_idle", 32'(idle), 32'd1);
    checkOutput("rst_sof", 32'(sof), 32'd0);
    checkOutput("rst_ready", 32'(din_ready), 32'd1);
    checkOutput("rst_ucnt", 32'(underrun_cnt), 32'd0);
    checkOutput("rst_ucnt_w4", 32'(underrun_cnt4), 32'd0);
    prbsIdx = 1;
  endtask

  // One clock edge: advance the slice-queue model and queue the expected cycle.
  task automatic applyStimulus();
    slice_t s;
    cyc_t   e;
    bit     under;
    @(posedge clk);
    lastXfer = din_valid && mReady;
    if (lastXfer) begin
      for (int i = 0; i < 4; i++) begin
        s.data = din[8*i +: 8];
        s.sof  = (i == 0);
        pend.push_back(s);
        dataQ.push_back(s);
      end
    end
    under = 1'b0;
    e.fill = 8'h00;
    if (pend.size() > 0) begin
      pend.delete(0);
      e.idle   = 1'b0;
      prevData = 1'b1;
    end else begin
      e.idle   = 1'b1;
      under    = prevData;
      prevData = 1'b0;
      e.fill   = fillNow();
      prbsIdx++;
    end
    if (clr_cnt) begin
      mUcnt  = '0;
      mUcnt4 = '0;
    end else if (under) begin
      if (mUcnt != 16'hFFFF) mUcnt++;
      if (mUcnt4 != 4'hF) mUcnt4++;
    end
    mReady  = (pend.size() < 4);
    e.ready = mReady;
    e.ucnt  = mUcnt;
    e.ucnt4 = mUcnt4;
    cycQ.push_back(e);
    #1;
  endtask

  task automatic sendWord(input logic [31:0] w);
    int tries;
    din       = w;
    din_valid = 1'b1;
    tries     = 0;
    do begin
      applyStimulus();
      tries++;
    end while (!lastXfer && tries < 16);
    if (!lastXfer) failNow("accept_timeout");
    din_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  // Monitor: pops one expected cycle per falling edge, and a data slice whenever the DUT shows data.
  initial begin
    cyc_t   e;
    slice_t d;
    forever begin
      @(negedge clk);
      if (monOn) begin
        if (cycQ.size() == 0) begin
          failNow("cycle_queue_empty");
        end else begin
          e = cycQ.pop_front();
          checkOutput("idle", 32'(idle), 32'(e.idle));
          checkOutput("idle_w4", 32'(idle4), 32'(e.idle));
          checkOutput("din_ready", 32'(din_ready), 32'(e.ready));
          checkOutput("din_ready_w4", 32'(din_ready4), 32'(e.ready));
          checkOutput("underrun_cnt", 32'(underrun_cnt), 32'(e.ucnt));
          checkOutput("underrun_cnt_w4", 32'(underrun_cnt4), 32'(e.ucnt4));
          if (e.idle) begin
            checkOutput("idle_fill", 32'(dout), 32'(e.fill));
            checkOutput("idle_sof", 32'(sof), 32'd0);
          end
          if (!idle) begin
            if (dataQ.size() == 0) begin
              failNow("unexpected_data");
            end else begin
              d = dataQ.pop_front();
              checkOutput("data", 32'(dout), 32'(d.data));
              checkOutput("data_sof", 32'(sof), 32'(d.sof));
              checkOutput("data_w4", 32'(dout4), 32'(d.data));
              checkOutput("data_sof_w4", 32'(sof4), 32'(d.sof));
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    monOn     = 1'b0;
    rst_n     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    clr_cnt   = 1'b0;
    resetModel();
    #12;
    checkReset();
    rst_n = 1'b1;
    applyStimulus();
    monOn = 1'b1;
    idleCycles(3);

    $display("[TB] single word");
    sendWord(32'hA1B2C3D4);
    idleCycles(6);

    $display("[TB] back-to-back words");
    sendWord(32'h00000001);
    sendWord(32'h00000002);
    sendWord(32'h00000003);
    idleCycles(8);

    $display("[TB] bypass on last slice");
    sendWord(32'h11223344);
    idleCycles(3);
    sendWord(32'h55667788);
    idleCycles(6);

    $display("[TB] counter clear and saturation");
    clr_cnt = 1'b1;
    applyStimulus();
    clr_cnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sendWord($urandom);
      idleCycles(5);
    end
    sendWord(32'hCAFEF00D);
    idleCycles(3);
    clr_cnt = 1'b1;
    applyStimulus();
    clr_cnt = 1'b0;
    idleCycles(2);
    for (int i = 0; i < 20; i++) begin
      sendWord($urandom);
      idleCycles(5);
    end

    $display("[TB] reset mid-word");
    sendWord(32'hDEADBEEF);
    idleCycles(2);
    monOn = 1'b0;
    resetModel();
    rst_n = 1'b0;
    #1;
    checkReset();
    #2;
    rst_n = 1'b1;
    applyStimulus();
    monOn = 1'b1;
    idleCycles(6);

    $display("[TB] long idle run");
    idleCycles(200);
    sendWord(32'h0BADC0DE);
    idleCycles(20);

    $display("[TB] random traffic");
    for (int n = 0; n < 1500; n++) begin
      if (!din_valid && ($urandom_range(0, 3) != 0)) begin
        din       = $urandom;
        din_valid = 1'b1;
      end
      clr_cnt = ($urandom_range(0, 99) == 0);
      applyStimulus();
      if (lastXfer) din_valid = 1'b0;
    end
    din_valid = 1'b0;
    clr_cnt   = 1'b0;
    idleCycles(10);
    @(negedge clk);
    checkOutput("data_drained", 32'(dataQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
